// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: sync + deglitch, 11-bit frame deserialise/check, E0/F0 prefix folding.
// Latency: code_valid 2 cycles after the filtered stop-bit falling edge (+1 through the FIFO).
// Backpressure: none by default; with PS2_RX_FIFO_EN a FIFO buffers codes and full drops raise overflow.
module ps2_kbd_rx #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 10000,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scancode,
    output logic       extended,
    output logic       released,
    output logic       code_valid,
    input  logic       code_ready,
    output logic       frame_err,
    output logic       overflow
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic [1:0]    r_clk_s, r_dat_s;
    logic          r_clk_f, r_clk_fd;
    logic [FW-1:0] r_fcnt;
    state_t        r_state;
    logic [7:0]    r_shift, r_byte;
    logic [2:0]    r_bitcnt;
    logic          r_par, r_byte_vld, r_err, r_err_clr;
    logic [TW-1:0] r_tcnt;
    logic          r_ext_p, r_brk_p, r_code_vld;
    logic [9:0]    r_code;
    logic          w_clk_sync, w_dat_sync, w_fall;

    assign w_clk_sync = r_clk_s[1];
    assign w_dat_sync = r_dat_s[1];
    assign w_fall     = r_clk_fd & ~r_clk_f;

    // Filtered clock only moves after the synchronised level differs for FILTER_LEN cycles in a row.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_clk_s  <= 2'b11;
            r_dat_s  <= 2'b11;
            r_clk_f  <= 1'b1;
            r_clk_fd <= 1'b1;
            r_fcnt   <= '0;
        end else begin
            r_clk_s  <= {r_clk_s[0], ps2_clk};
            r_dat_s  <= {r_dat_s[0], ps2_data};
            r_clk_fd <= r_clk_f;
            if (w_clk_sync == r_clk_f) begin
                r_fcnt <= '0;
            end else if (r_fcnt == FW'(FILTER_LEN - 1)) begin
                r_clk_f <= w_clk_sync;
                r_fcnt  <= '0;
            end else begin
                r_fcnt <= r_fcnt + FW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_byte     <= '0;
            r_bitcnt   <= '0;
            r_par      <= 1'b0;
            r_tcnt     <= '0;
            r_byte_vld <= 1'b0;
            r_err      <= 1'b0;
            r_err_clr  <= 1'b0;
        end else begin
            r_byte_vld <= 1'b0;
            r_err      <= 1'b0;
            r_err_clr  <= 1'b0;
            if (r_state == S_IDLE || w_fall)
                r_tcnt <= '0;
            else
                r_tcnt <= r_tcnt + TW'(1);
            // A timeout abandons the frame but leaves any pending prefix flags alone.
            if (r_state != S_IDLE && !w_fall && r_tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                r_state <= S_IDLE;
                r_err   <= 1'b1;
            end else if (w_fall) begin
                case (r_state)
                    S_IDLE: begin
                        if (!w_dat_sync) begin
                            r_state  <= S_DATA;
                            r_bitcnt <= '0;
                        end else begin
                            r_err     <= 1'b1;
                            r_err_clr <= 1'b1;
                        end
                    end
                    S_DATA: begin
                        r_shift  <= {w_dat_sync, r_shift[7:1]};
                        r_bitcnt <= r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7)
                            r_state <= S_PARITY;
                    end
                    S_PARITY: begin
                        r_par   <= w_dat_sync;
                        r_state <= S_STOP;
                    end
                    S_STOP: begin
                        r_state <= S_IDLE;
                        if (w_dat_sync && (^{r_shift, r_par})) begin
                            r_byte_vld <= 1'b1;
                            r_byte     <= r_shift;
                        end else begin
                            r_err     <= 1'b1;
                            r_err_clr <= 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ext_p    <= 1'b0;
            r_brk_p    <= 1'b0;
            r_code_vld <= 1'b0;
            r_code     <= '0;
        end else begin
            r_code_vld <= 1'b0;
            if (r_err_clr) begin
                r_ext_p <= 1'b0;
                r_brk_p <= 1'b0;
            end else if (r_byte_vld) begin
                if (r_byte == 8'hE0) begin
                    r_ext_p <= 1'b1;
                end else if (r_byte == 8'hF0) begin
                    r_brk_p <= 1'b1;
                end else begin
                    r_code_vld <= 1'b1;
                    r_code     <= {r_byte, r_ext_p, r_brk_p};
                    r_ext_p    <= 1'b0;
                    r_brk_p    <= 1'b0;
                end
            end
        end
    end

    assign frame_err = r_err;

`ifdef PS2_RX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [9:0]  r_mem [FIFO_DEPTH];
    logic [AW:0] r_wp, r_rp;
    logic        r_ovf;
    logic        w_empty, w_full, w_pop, w_push;
    logic [9:0]  w_head;

    assign w_empty = (r_wp == r_rp);
    assign w_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign w_pop   = ~w_empty & code_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign w_push  = r_code_vld & (~w_full | w_pop);
    assign w_head  = r_mem[r_rp[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_ovf <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                r_mem[i] <= '0;
        end else begin
            r_ovf <= r_code_vld & w_full & ~w_pop;
            if (w_push) begin
                r_mem[r_wp[AW-1:0]] <= r_code;
                r_wp <= r_wp + (AW+1)'(1);
            end
            if (w_pop)
                r_rp <= r_rp + (AW+1)'(1);
        end
    end

    assign scancode   = w_head[9:2];
    assign extended   = w_head[1];
    assign released   = w_head[0];
    assign code_valid = ~w_empty;
    assign overflow   = r_ovf;
`else
    logic w_unused;
    assign w_unused   = code_ready & (FIFO_DEPTH > 0);
    assign scancode   = r_code[9:2];
    assign extended   = r_code[1];
    assign released   = r_code[0];
    assign code_valid = r_code_vld;
    assign overflow   = 1'b0;
`endif
endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Bench for ps2_kbd_rx: directed frames plus randomized byte streams scored against a prefix-folding model.
module tb_ps2_kbd_rx;
    localparam bit FIFO_EN =
`ifdef PS2_RX_FIFO_EN
        1'b1;
`else
        1'b0;
`endif
    localparam int HALF = 12;
    // 2 synchroniser stages + FILTER_LEN filter cycles + 2 cycles from filtered edge to code_valid
    localparam int LAT = 2 + 4 + 2 + (FIFO_EN ? 1 : 0);

    logic       clk = 1'b0, reset_n = 1'b0;
    logic       ps2_clk = 1'b1, ps2_data = 1'b1, code_ready = 1'b1;
    logic [7:0] scancode;
    logic       extended, released, code_valid, frame_err, overflow;

    ps2_kbd_rx #(.FILTER_LEN(4), .TIMEOUT_CYCLES(10000), .FIFO_DEPTH(8)) dut (
        .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .scancode(scancode), .extended(extended), .released(released),
        .code_valid(code_valid), .code_ready(code_ready),
        .frame_err(frame_err), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;
    int cyc = 0, t_stop = 0, last_cyc = 0;
    int fe_cnt = 0, fe_exp = 0, ov_cnt = 0, wide_cnt = 0;
    logic prev_vld = 1'b0;
    logic [9:0] got_q[$];
    logic [9:0] exp_q[$];
    logic m_ext = 1'b0, m_brk = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (reset_n) begin
            if (code_valid && (code_ready || !FIFO_EN)) begin
                got_q.push_back({scancode, extended, released});
                last_cyc = cyc;
            end
            if (!FIFO_EN && code_valid && prev_vld) wide_cnt++;
            prev_vld = code_valid;
            if (frame_err) fe_cnt++;
            if (overflow) ov_cnt++;
        end else begin
            prev_vld = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ps2_bit(input logic b, input bit mark);
        ps2_data = b;
        wait_cyc(HALF);
        ps2_clk = 1'b0;
        if (mark) t_stop = cyc;
        wait_cyc(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                             input int nbits, input int glitch_after);
        logic [10:0] bits;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_bit(bits[i], i == 10);
            if (i == glitch_after) begin
                wait_cyc(4);
                ps2_clk = 1'b0;
                wait_cyc(2);
                ps2_clk = 1'b1;
                wait_cyc(4);
            end
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        send_bits(b, bad_par, bad_stop, 11, -1);
        wait_cyc(30);
    endtask

    // Reference: bytes in, folded codes out, straight from the prefix rules.
    task automatic model_byte(input logic [7:0] b, input bit good);
        if (!good) begin
            fe_exp++;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            exp_q.push_back({b, m_ext, m_brk});
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic compare_q(input string tag);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0)
            chk({tag, "_code"}, got_q.pop_front(), exp_q.pop_front());
        got_q.delete();
        exp_q.delete();
        chk({tag, "_ferr"}, fe_cnt, fe_exp);
    endtask

    initial begin
        wait_cyc(3);
        chk("reset_out", {scancode, extended, released, code_valid, frame_err, overflow}, 32'h0);
        reset_n = 1'b1;
        wait_cyc(5);

        exp_q.push_back({8'h1C, 2'b00});
        send_frame(8'h1C, 0, 0);
        chk("latency", last_cyc - t_stop, LAT);
        compare_q("single_1c");

        send_frame(8'hE0, 0, 0);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h75, 0, 0);
        exp_q.push_back({8'h75, 2'b11});
        compare_q("e0_f0_75");
        send_frame(8'h75, 0, 0);
        exp_q.push_back({8'h75, 2'b00});
        compare_q("plain_75");

        send_frame(8'h1C, 1, 0);
        fe_exp++;
        compare_q("bad_parity");
        send_frame(8'hF0, 0, 0);
        send_frame(8'h33, 0, 1);
        fe_exp++;
        send_frame(8'h1C, 0, 0);
        exp_q.push_back({8'h1C, 2'b00});
        compare_q("bad_stop_clears");

        send_bits(8'h29, 0, 0, 5, -1);
        wait_cyc(10001);
        fe_exp++;
        compare_q("timeout");
        send_frame(8'h29, 0, 0);
        exp_q.push_back({8'h29, 2'b00});
        compare_q("after_timeout");

        send_bits(8'h1C, 0, 0, 11, 4);
        wait_cyc(30);
        exp_q.push_back({8'h1C, 2'b00});
        compare_q("glitch");

        send_bits(8'h5A, 0, 0, 4, -1);
        reset_n = 1'b0;
        wait_cyc(2);
        chk("midframe_reset_out", {scancode, extended, released, code_valid, frame_err, overflow}, 32'h0);
        reset_n = 1'b1;
        wait_cyc(5);
        send_frame(8'h5A, 0, 0);
        exp_q.push_back({8'h5A, 2'b00});
        compare_q("after_reset");

        send_frame(8'hE0, 0, 0);
        ps2_bit(1'b1, 0);
        wait_cyc(30);
        fe_exp++;
        send_frame(8'h6B, 0, 0);
        exp_q.push_back({8'h6B, 2'b00});
        compare_q("bad_start_clears");

        m_ext = 1'b0;
        m_brk = 1'b0;
        for (int k = 0; k < 40; k++) begin
            int r;
            logic [7:0] b;
            bit bad_p, bad_s;
            r = $urandom_range(0, 9);
            b = (r < 2) ? 8'hE0 : (r < 4) ? 8'hF0 : 8'($urandom);
            bad_p = ($urandom_range(0, 11) == 0);
            bad_s = ($urandom_range(0, 11) == 0);
            send_frame(b, bad_p, bad_s);
            model_byte(b, !(bad_p || bad_s));
        end
        compare_q("random");

`ifdef PS2_RX_FIFO_EN
        code_ready = 1'b0;
        for (int k = 1; k <= 8; k++) send_frame(8'(k), 0, 0);
        chk("fifo_no_ovf_8", ov_cnt, 0);
        send_frame(8'h09, 0, 0);
        chk("fifo_ovf_9th", ov_cnt, 1);
        chk("fifo_full_valid", code_valid, 1);
        code_ready = 1'b1;
        wait_cyc(12);
        chk("fifo_drained", code_valid, 0);
        for (int k = 1; k <= 8; k++) exp_q.push_back({8'(k), 2'b00});
        compare_q("fifo_order");
`else
        chk("no_overflow", ov_cnt, 0);
        chk("pulse_width", wide_cnt, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
